hazard_stall_controller: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS datapath. There is no forwarding.
- Keeps an internal scoreboard of in-flight destination registers for the EX, MEM and WB stages.
- Stalls PC and IF/ID and injects ID/EX bubbles on RAW hazards against the instruction in ID.
- Flushes IF/ID, ID/EX and EX/MEM when a taken branch resolves in MEM. Also provides saturating stall and flush performance counters.

---
 rtl/hazard_stall_controller.sv | 181 ++++++++++++++++++
 tb/tb_hazard_stall_controller.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// Hazard controller for a 5-stage MIPS pipeline without forwarding: tracks in-flight
// destination registers, stalls on RAW hazards in ID and flushes on taken branches in MEM.
module hazard_stall_controller #(
    parameter int CNT_W     = 16,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       id_dest,
    input  logic             id_RegWrite,
    input  logic             mem_branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic             r_ex_v;
    logic [4:0]       r_ex_d;
    logic             r_mem_v;
    logic [4:0]       r_mem_d;
    logic             r_wb_v;
    logic [4:0]       r_wb_d;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_rs_hit;
    logic             w_rt_hit;
    logic             w_hazard;
    logic             w_id_wr;
    state_t           w_action;

    // A source matches a slot only when it is actually read and is not $zero.
    function automatic logic src_hit(
        input logic       use_f,
        input logic [4:0] src,
        input logic       ex_v,
        input logic [4:0] ex_d,
        input logic       mem_v,
        input logic [4:0] mem_d,
        input logic       wb_v,
        input logic [4:0] wb_d,
        input logic       chk_wb
    );
        logic hit;
        hit = 1'b0;
        if (use_f && (src != 5'd0)) begin
            hit = (ex_v && (ex_d == src)) ||
                  (mem_v && (mem_d == src)) ||
                  (chk_wb && wb_v && (wb_d == src));
        end else begin
            hit = 1'b0;
        end
        return hit;
    endfunction

    // Hazard detection and action selection: flush beats stall beats run.
    always_comb begin
        w_rs_hit = src_hit(id_uses_rs, id_rs, r_ex_v, r_ex_d, r_mem_v, r_mem_d,
                           r_wb_v, r_wb_d, !WB_BYPASS);
        w_rt_hit = src_hit(id_uses_rt, id_rt, r_ex_v, r_ex_d, r_mem_v, r_mem_d,
                           r_wb_v, r_wb_d, !WB_BYPASS);
        w_hazard = id_valid & (w_rs_hit | w_rt_hit);
        w_id_wr  = id_valid & id_RegWrite & (id_dest != 5'd0);
        if (mem_branch_taken) begin
            w_action = ST_FLUSH;
        end else if (w_hazard) begin
            w_action = ST_STALL;
        end else begin
            w_action = ST_RUN;
        end
    end

    // Pipeline control outputs decoded from the current action.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        case (w_action)
            ST_FLUSH: begin
                idex_bubble = 1'b1;
                flush_ifid  = 1'b1;
                flush_idex  = 1'b1;
                flush_exmem = 1'b1;
            end
            ST_STALL: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
            default: begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
            end
        endcase
    end

    // Scoreboard shift and previous-action register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_ex_v  <= 1'b0;
            r_ex_d  <= 5'd0;
            r_mem_v <= 1'b0;
            r_mem_d <= 5'd0;
            r_wb_v  <= 1'b0;
            r_wb_d  <= 5'd0;
        end else begin
            r_state <= w_action;
            r_wb_v  <= r_mem_v;
            r_wb_d  <= r_mem_d;
            case (w_action)
                ST_FLUSH: begin
                    r_ex_v  <= 1'b0;
                    r_ex_d  <= 5'd0;
                    r_mem_v <= 1'b0;
                    r_mem_d <= 5'd0;
                end
                ST_STALL: begin
                    r_ex_v  <= 1'b0;
                    r_ex_d  <= 5'd0;
                    r_mem_v <= r_ex_v;
                    r_mem_d <= r_ex_d;
                end
                default: begin
                    r_ex_v  <= w_id_wr;
                    r_ex_d  <= id_dest;
                    r_mem_v <= r_ex_v;
                    r_mem_d <= r_ex_d;
                end
            endcase
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= {CNT_W{1'b0}};
            r_flush_cnt <= {CNT_W{1'b0}};
        end else begin
            if ((w_action == ST_STALL) && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if ((w_action == ST_FLUSH) && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    assign state        = r_state;
    assign stall_cycles = r_stall_cnt;
    assign flush_events = r_flush_cnt;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench: two controller instances (WB_BYPASS=0/CNT_W=16 and WB_BYPASS=1/CNT_W=4)
// share stimulus; each queued expectation names the instance it checks.
module tb_hazard_stall_controller;

    typedef struct {
        int         sel;
        logic [5:0] ctl;
        logic [1:0] st;
        int         stl;
        int         fl;
        string      tag;
    } exp_t;

    localparam logic [5:0] C_RUN = 6'b110000;
    localparam logic [5:0] C_STL = 6'b001000;
    localparam logic [5:0] C_FLS = 6'b111111;

    logic clk;
    logic reset;
    logic id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic id_uses_rs;
    logic id_uses_rt;
    logic [4:0] id_dest;
    logic id_RegWrite;
    logic mem_branch_taken;

    logic a_pw, a_iw, a_bub, a_fi, a_fd, a_fe;
    logic [1:0] a_st;
    logic [15:0] a_stl, a_fl;
    logic b_pw, b_iw, b_bub, b_fi, b_fd, b_fe;
    logic [1:0] b_st;
    logic [3:0] b_stl, b_fl;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    string tname = "init";
    int cyc_no = 0;

    hazard_stall_controller #(.CNT_W(16), .WB_BYPASS(1'b0)) dut_nob (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
        .id_RegWrite(id_RegWrite), .mem_branch_taken(mem_branch_taken),
        .pc_write(a_pw), .ifid_write(a_iw), .idex_bubble(a_bub), .flush_ifid(a_fi),
        .flush_idex(a_fd), .flush_exmem(a_fe), .state(a_st),
        .stall_cycles(a_stl), .flush_events(a_fl)
    );

    hazard_stall_controller #(.CNT_W(4), .WB_BYPASS(1'b1)) dut_byp (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
        .id_RegWrite(id_RegWrite), .mem_branch_taken(mem_branch_taken),
        .pc_write(b_pw), .ifid_write(b_iw), .idex_bubble(b_bub), .flush_ifid(b_fi),
        .flush_idex(b_fd), .flush_exmem(b_fe), .state(b_st),
        .stall_cycles(b_stl), .flush_events(b_fl)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs at the falling edge and queue the expected response.
    task automatic cyc(input bit rst_v, input bit v, input logic [4:0] rs, input bit urs,
                       input logic [4:0] rt, input bit urt, input logic [4:0] dst,
                       input bit rw, input bit br, input int sel, input logic [5:0] ctl,
                       input logic [1:0] st, input int stl, input int fl);
        exp_t e;
        @(negedge clk);
        reset = rst_v; id_valid = v; id_rs = rs; id_uses_rs = urs; id_rt = rt;
        id_uses_rt = urt; id_dest = dst; id_RegWrite = rw; mem_branch_taken = br;
        cyc_no++;
        e.sel = sel; e.ctl = ctl; e.st = st; e.stl = stl; e.fl = fl;
        e.tag = $sformatf("%s#%0d", tname, cyc_no);
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input int sel);
        cyc_no = 0;
        cyc(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, sel, C_RUN, 2'd0, 0, 0);
        cyc(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, sel, C_RUN, 2'd0, 0, 0);
    endtask

    function automatic int sat15(input int x);
        return (x > 15) ? 15 : x;
    endfunction

    // Monitor: pops expectations and compares against the selected instance.
    initial begin
        exp_t e;
        logic [5:0] g_ctl;
        logic [1:0] g_st;
        int g_stl, g_fl;
        forever begin
            @(negedge clk);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.sel == 0) begin
                    g_ctl = {a_pw, a_iw, a_bub, a_fi, a_fd, a_fe};
                    g_st = a_st; g_stl = int'(a_stl); g_fl = int'(a_fl);
                end else begin
                    g_ctl = {b_pw, b_iw, b_bub, b_fi, b_fd, b_fe};
                    g_st = b_st; g_stl = int'(b_stl); g_fl = int'(b_fl);
                end
                n_cmp++;
                if (g_ctl !== e.ctl) begin
                    n_bad++;
                    $display("FAIL %s ctl: got %b want %b", e.tag, g_ctl, e.ctl);
                end
                n_cmp++;
                if (g_st !== e.st) begin
                    n_bad++;
                    $display("FAIL %s state: got %0d want %0d", e.tag, g_st, e.st);
                end
                n_cmp++;
                if (g_stl != e.stl) begin
                    n_bad++;
                    $display("FAIL %s stall_cycles: got %0d want %0d", e.tag, g_stl, e.stl);
                end
                n_cmp++;
                if (g_fl != e.fl) begin
                    n_bad++;
                    $display("FAIL %s flush_events: got %0d want %0d", e.tag, g_fl, e.fl);
                end
            end
        end
    end

    initial begin
        int s;
        reset = 1'b1; id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0;
        id_uses_rt = 1'b0; id_dest = 5'd0; id_RegWrite = 1'b0; mem_branch_taken = 1'b0;

        // Back-to-back RAW, WB bypassed: two stall cycles.
        tname = "raw_byp";
        do_reset(1);
        cyc(0, 1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 1, C_RUN, 2'd0, 0, 0);
        cyc(0, 1, 5'd3, 1, 5'd4, 1, 5'd5, 1, 0, 1, C_STL, 2'd0, 0, 0);
        cyc(0, 1, 5'd3, 1, 5'd4, 1, 5'd5, 1, 0, 1, C_STL, 2'd1, 1, 0);
        cyc(0, 1, 5'd3, 1, 5'd4, 1, 5'd5, 1, 0, 1, C_RUN, 2'd1, 2, 0);
        cyc(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, C_RUN, 2'd0, 2, 0);

        // Back-to-back RAW, WB checked: three stall cycles.
        tname = "raw_nob";
        do_reset(0);
        cyc(0, 1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, C_RUN, 2'd0, 0, 0);
        cyc(0, 1, 5'd4, 1, 5'd3, 1, 5'd5, 1, 0, 0, C_STL, 2'd0, 0, 0);
        cyc(0, 1, 5'd4, 1, 5'd3, 1, 5'd5, 1, 0, 0, C_STL, 2'd1, 1, 0);
        cyc(0, 1, 5'd4, 1, 5'd3, 1, 5'd5, 1, 0, 0, C_STL, 2'd1, 2, 0);
        cyc(0, 1, 5'd4, 1, 5'd3, 1, 5'd5, 1, 0, 0, C_RUN, 2'd1, 3, 0);
        cyc(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, C_RUN, 2'd0, 3, 0);

        // $zero, invalid ID, unused source and independent registers never stall.
        tname = "nohaz";
        do_reset(1);
        cyc(0, 1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 0, 1, C_RUN, 2'd0, 0, 0);
        cyc(0, 1, 5'd0, 1, 5'd0, 1, 5'd3, 1, 0, 1, C_RUN, 2'd0, 0, 0);
        cyc(0, 0, 5'd3, 1, 5'd3, 1, 5'd4, 1, 0, 1, C_RUN, 2'd0, 0, 0);
        cyc(0, 1, 5'd3, 0, 5'd7, 1, 5'd8, 0, 0, 1, C_RUN, 2'd0, 0, 0);
        cyc(0, 1, 5'd5, 1, 5'd6, 1, 5'd9, 0, 0, 1, C_RUN, 2'd0, 0, 0);

        // Flush overrides a pending hazard; reissued consumer runs.
        tname = "flush";
        do_reset(1);
        cyc(0, 1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 1, C_RUN, 2'd0, 0, 0);
        cyc(0, 1, 5'd3, 1, 5'd4, 1, 5'd5, 1, 1, 1, C_FLS, 2'd0, 0, 0);
        cyc(0, 1, 5'd3, 1, 5'd4, 1, 5'd5, 1, 0, 1, C_RUN, 2'd2, 0, 1);
        cyc(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, C_RUN, 2'd0, 0, 1);

        // Flush moves the MEM producer into WB, which the WB-checking instance sees.
        tname = "flush_wb";
        do_reset(0);
        cyc(0, 1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, C_RUN, 2'd0, 0, 0);
        cyc(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, C_RUN, 2'd0, 0, 0);
        cyc(0, 1, 5'd3, 1, 5'd4, 1, 5'd5, 1, 1, 0, C_FLS, 2'd0, 0, 0);
        cyc(0, 1, 5'd3, 1, 5'd4, 1, 5'd5, 1, 0, 0, C_STL, 2'd2, 0, 1);
        cyc(0, 1, 5'd3, 1, 5'd4, 1, 5'd5, 1, 0, 0, C_RUN, 2'd1, 1, 1);

        // Reset in the middle of a stall clears everything.
        tname = "rst_mid";
        do_reset(1);
        cyc(0, 1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 1, C_RUN, 2'd0, 0, 0);
        cyc(0, 1, 5'd3, 1, 5'd4, 1, 5'd5, 1, 0, 1, C_STL, 2'd0, 0, 0);
        cyc(1, 1, 5'd3, 1, 5'd4, 1, 5'd5, 1, 0, 1, C_RUN, 2'd0, 0, 0);
        cyc(0, 1, 5'd3, 1, 5'd4, 1, 5'd5, 1, 0, 1, C_RUN, 2'd0, 0, 0);
        cyc(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, C_RUN, 2'd0, 0, 0);

        // 20 stall cycles on the 4-bit counter saturate at 15.
        tname = "sat";
        do_reset(1);
        s = 0;
        for (int p = 0; p < 10; p++) begin
            cyc(0, 1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 1, C_RUN, 2'd0, s, 0);
            cyc(0, 1, 5'd3, 1, 5'd4, 1, 5'd5, 0, 0, 1, C_STL, 2'd0, s, 0);
            s = sat15(s + 1);
            cyc(0, 1, 5'd3, 1, 5'd4, 1, 5'd5, 0, 0, 1, C_STL, 2'd1, s, 0);
            s = sat15(s + 1);
            cyc(0, 1, 5'd3, 1, 5'd4, 1, 5'd5, 0, 0, 1, C_RUN, 2'd1, s, 0);
        end
        cyc(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, C_RUN, 2'd0, 15, 0);

        @(negedge clk);
        #5;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
